// File: rtl/phys_free_list_if.sv
// Rename-side bus of the physical register free list: allocation, ROB retire frees, status.
// PHYS_FREE_LIST_DUPCHK_EN adds the sticky err_dup status bit.
interface phys_free_list_if #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned TAG_W     = 6
);
  logic                 alloc_req;
  logic [TAG_W-1:0]     alloc_tag;
  logic                 alloc_valid;
  logic                 stall;
  logic [NUM_PREGS-1:0] retire_vec;
  logic [TAG_W:0]       free_count;
  logic                 err_overflow;
`ifdef PHYS_FREE_LIST_DUPCHK_EN
  logic                 err_dup;

  modport master (
    output alloc_req, retire_vec,
    input  alloc_tag, alloc_valid, stall, free_count, err_overflow, err_dup
  );
  modport slave (
    input  alloc_req, retire_vec,
    output alloc_tag, alloc_valid, stall, free_count, err_overflow, err_dup
  );
`else
  modport master (
    output alloc_req, retire_vec,
    input  alloc_tag, alloc_valid, stall, free_count, err_overflow
  );
  modport slave (
    input  alloc_req, retire_vec,
    output alloc_tag, alloc_valid, stall, free_count, err_overflow
  );
`endif
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags: one alloc per cycle, up to two retire frees per cycle.
// PHYS_FREE_LIST_DUPCHK_EN: in_list bitmap drops frees of tags already in the list and flags err_dup.
module phys_free_list #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_AREGS = 32,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned MAX_FREE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  phys_free_list_if.slave  fl
);

  localparam int unsigned CNT_W = TAG_W + 1;
  localparam int unsigned FREE0 = NUM_PREGS - NUM_AREGS;

  logic [TAG_W-1:0] mem_q [NUM_PREGS];
  logic [TAG_W-1:0] mem_d [NUM_PREGS];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_ovf_q, err_ovf_d;

  logic [NUM_PREGS-1:0] cand;
  logic                 sel_a_v, sel_b_v;
  logic [TAG_W-1:0]     sel_a, sel_b;
  logic [CNT_W-1:0]     nset;
  logic                 excess;
  logic                 dup_a, dup_b;
  logic                 ok_a, ok_b;
  logic [TAG_W-1:0]     push_tag0, push_tag1;
  logic [1:0]           n_req, n_take;
  logic [CNT_W-1:0]     space;
  logic                 alloc_acc;

`ifdef PHYS_FREE_LIST_DUPCHK_EN
  logic [NUM_PREGS-1:0] in_list_q, in_list_d;
  logic                 err_dup_q, err_dup_d;
`endif

  // Pick the two lowest set retire bits above p0 and count the rest for overflow
  always_comb begin
    cand    = fl.retire_vec & ~(NUM_PREGS'(1));
    sel_a_v = 1'b0;
    sel_b_v = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    nset    = '0;
    for (int unsigned i = 0; i < NUM_PREGS; i++) begin
      if (cand[TAG_W'(i)]) begin
        if (!sel_a_v) begin
          sel_a_v = 1'b1;
          sel_a   = TAG_W'(i);
        end else if (!sel_b_v) begin
          sel_b_v = 1'b1;
          sel_b   = TAG_W'(i);
        end
        nset = nset + CNT_W'(1);
      end
    end
    excess = nset > CNT_W'(MAX_FREE);
  end

  // Compact surviving frees, clip to free space, compute next state
  always_comb begin
`ifdef PHYS_FREE_LIST_DUPCHK_EN
    dup_a = sel_a_v & in_list_q[sel_a];
    dup_b = sel_b_v & in_list_q[sel_b];
`else
    dup_a = 1'b0;
    dup_b = 1'b0;
`endif
    ok_a      = sel_a_v & ~dup_a;
    ok_b      = sel_b_v & ~dup_b;
    push_tag0 = ok_a ? sel_a : sel_b;
    push_tag1 = sel_b;
    n_req     = 2'(ok_a) + 2'(ok_b);
    alloc_acc = fl.alloc_req & (count_q != '0);
    // An accepted alloc frees its slot for a same-cycle push
    space     = CNT_W'(NUM_PREGS) - count_q + CNT_W'(alloc_acc);
    n_take    = (CNT_W'(n_req) > space) ? space[1:0] : n_req;

    mem_d = mem_q;
    if (n_take != 2'd0) mem_d[tail_q] = push_tag0;
    if (n_take == 2'd2) mem_d[tail_q + TAG_W'(1)] = push_tag1;

    head_d    = head_q + TAG_W'(alloc_acc);
    tail_d    = tail_q + TAG_W'(n_take);
    count_d   = count_q + CNT_W'(n_take) - CNT_W'(alloc_acc);
    err_ovf_d = err_ovf_q | excess | (n_take != n_req);

`ifdef PHYS_FREE_LIST_DUPCHK_EN
    in_list_d = in_list_q;
    if (alloc_acc) in_list_d[mem_q[head_q]] = 1'b0;
    if (n_take != 2'd0) in_list_d[push_tag0] = 1'b1;
    if (n_take == 2'd2) in_list_d[push_tag1] = 1'b1;
    err_dup_d = err_dup_q | dup_a | dup_b;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++) begin
        mem_q[TAG_W'(i)] <= (i < FREE0) ? TAG_W'(NUM_AREGS + i) : '0;
      end
      head_q    <= '0;
      tail_q    <= TAG_W'(FREE0);
      count_q   <= CNT_W'(FREE0);
      err_ovf_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
    end
  end

`ifdef PHYS_FREE_LIST_DUPCHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++) begin
        in_list_q[TAG_W'(i)] <= (i >= NUM_AREGS);
      end
      err_dup_q <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      err_dup_q <= err_dup_d;
    end
  end

  assign fl.err_dup = err_dup_q;
`endif

  assign fl.alloc_tag    = mem_q[head_q];
  assign fl.alloc_valid  = (count_q != '0);
  assign fl.stall        = fl.alloc_req & (count_q == '0);
  assign fl.free_count   = count_q;
  assign fl.err_overflow = err_ovf_q;

endmodule

// File: doc/phys_free_list.md
Name: phys_free_list

Overview:
- Circular free list of physical register tags for the rename stage.
- Supplies one new destination tag per cycle to rename/dispatch.
- Reclaims old destination tags that the ROB retires, delivered as the 64-bit one-hot/multi-hot retire vector (up to 2 bits per cycle).
- Raises stall to dispatch when no tag is available.

Parameters:
- NUM_PREGS, 64: physical register count; also the FIFO depth.
- NUM_AREGS, 32: architectural registers. p0..p31 are mapped at reset; p32..p63 start free.
- TAG_W, 6: tag width, log2(NUM_PREGS).
- MAX_FREE, 2: maximum tags reclaimed per cycle; matches the ROB retire width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- alloc_req  input  1  rename requests one tag this cycle.
- alloc_tag  output  TAG_W  tag at FIFO head; valid when alloc_valid=1.
- alloc_valid  output  1  list non-empty (count!=0).
- stall  output  1  alloc_req=1 and count==0.
- retire_vec  input  NUM_PREGS  ROB retire vector; bit i=1 frees tag i.
- free_count  output  TAG_W+1  tags currently in the list.
- err_overflow  output  1  sticky; set on any dropped free.

Behaviour:
- Storage: mem[NUM_PREGS] of TAG_W bits, head and tail pointers of TAG_W bits, count of TAG_W+1 bits.
- Reset (rst=1 at posedge): mem[i]=NUM_AREGS+i for i<NUM_PREGS-NUM_AREGS, others 0; head=0; tail=32; count=32; err_overflow=0. Reset mid-operation discards all in-flight frees and allocs that cycle.
- alloc_tag=mem[head] and alloc_valid=(count!=0), both combinational from registered state.
- stall=alloc_req & (count==0), combinational.
- Allocate: alloc_req & alloc_valid at posedge -> head=head+1 (mod NUM_PREGS). alloc_req while empty is ignored; head and count unchanged.
- Free selection: scan retire_vec from bit 1 upward, ignoring bit 0 (p0 is never freed). Take the lowest MAX_FREE set bits.
  - First selected bit -> mem[tail].
  - Second selected bit -> mem[tail+1].
  - tail advances by the number taken (0..2), mod NUM_PREGS.
- More than MAX_FREE set bits (excluding bit 0): extra bits are dropped and err_overflow is set.
- Full: a free that would make count exceed NUM_PREGS is dropped (double free) and err_overflow is set.
- Count update: count_next = count + nfree - (alloc accepted).
- Simultaneous alloc and free are both legal in the same cycle, including when count==0.
- A tag freed in cycle N is not bypassed to alloc_tag in cycle N; it is visible at the earliest in cycle N+1, and only once it reaches the head.
- Wrap-around: head and tail are modulo NUM_PREGS; ordering stays strict FIFO across the wrap.
- err_overflow clears only on rst.

Optional Feature:
- Macro: PHYS_FREE_LIST_DUPCHK_EN.
- Defined:
  - Adds a NUM_PREGS-bit in_list bitmap. Reset value: bits 32..63 = 1, others 0.
  - Allocate clears in_list[alloc_tag]. Free sets the bit.
  - A free of a tag whose in_list bit is already 1 is dropped (not pushed) and sets a sticky output err_dup, which is 1 bit.
- Undefined: no bitmap and no err_dup port; duplicate frees are pushed unchecked.

Test Plan:
- Reset: assert rst 1 cycle -> alloc_tag=32, alloc_valid=1, free_count=32, stall=0, err_overflow=0.
- Drain: alloc_req=1 for 32 cycles -> tags 32..63 in order; then free_count=0, alloc_valid=0, and stall=1 while alloc_req=1.
- Dual free: from empty, retire_vec bits 40 and 35 set -> next cycle free_count=2, alloc_tag=35; after one alloc, alloc_tag=40.
- Simultaneous alloc and free: count=1 with head tag 50; alloc_req=1 and retire_vec bit 7 set -> next cycle free_count=1, alloc_tag=7.
- Wrap-around: alloc 60 tags and free 60 tags interleaved -> pointers wrap past 63, FIFO order is preserved, free_count stays consistent.
- Illegal frees: retire_vec bits 0, 3, 5, 9 set -> tags 3 and 5 pushed, 9 dropped, err_overflow=1, bit 0 ignored. With PHYS_FREE_LIST_DUPCHK_EN defined, freeing tag 33 at reset -> err_dup=1 and free_count stays 32.
